// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: datapath and controller in one block, with a
// single shared memory port (req/ready) for instruction fetch and data access.
module multicycle_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_out,
   output logic        retire,
   output logic        halted
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} stateT;

   stateT       state;
   stateT       nextState;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] regA;
   logic [31:0] regB;
   logic [31:0] immExt;
   logic [31:0] aluOut;
   logic [31:0] mdr;
   logic [31:0] regFile [32];
   logic        memReq;
   logic        retireReg;

   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic        accept;
   logic        isLegal;
   logic [31:0] rsData;
   logic [31:0] rtData;
   logic [31:0] aluResult;
   logic        memReqNext;
   logic        retireNext;
   logic [4:0]  wbIdx;
   logic [31:0] wbData;
   logic        wbEnable;

   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign funct  = instr[5:0];

   // A memory access only completes when we are actually requesting; a stray
   // ready while idle is ignored.
   assign accept = memReq && mem_ready;

   assign mem_req   = memReq;
   assign mem_we    = memReq && (state == MEM) && (opcode == OP_SW);
   assign mem_addr  = (state == MEM) ? {aluOut[31:2], 2'b00} : pc;
   assign mem_wdata = regB;
   assign pc_out    = pc;
   assign retire    = retireReg;
   assign halted    = (state == HALT);

   // Register file read ports: r0 and any index beyond the implemented range
   // always read as zero.
   always_comb begin
      rsData = '0;
      rtData = '0;
      if (rs != 5'd0 && int'(rs) < NUM_REGS) rsData = regFile[rs];
      if (rt != 5'd0 && int'(rt) < NUM_REGS) rtData = regFile[rt];
   end

   // Classify the fetched instruction; anything not in the supported subset
   // sends the core to HALT from DECODE.
   always_comb begin
      isLegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: isLegal = 1'b1;
               default:                               isLegal = 1'b0;
            endcase
         end
         OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: isLegal = 1'b1;
         default:                             isLegal = 1'b0;
      endcase
   end

   // ALU: R-type ops use A and B, everything else computes A + imm (addi and
   // the load/store effective address). slt compares as signed.
   always_comb begin
      aluResult = regA + immExt;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_SUB:  aluResult = regA - regB;
            FN_AND:  aluResult = regA & regB;
            FN_OR:   aluResult = regA | regB;
            FN_SLT:  aluResult = {31'b0, $signed(regA) < $signed(regB)};
            default: aluResult = regA + regB;
         endcase
      end
   end

   // Write-back target and data: R-type writes rd, addi/lw write rt; writes to
   // r0 or unimplemented registers are simply dropped.
   always_comb begin
      wbIdx    = (opcode == OP_RTYPE) ? rd : rt;
      wbData   = (opcode == OP_LW) ? mdr : aluOut;
      wbEnable = (wbIdx != 5'd0) && (int'(wbIdx) < NUM_REGS);
   end

   // Next-state logic plus the next values of the registered request and
   // retire outputs, so mem_req is high exactly during FETCH/MEM.
   always_comb begin
      nextState  = state;
      retireNext = 1'b0;
      case (state)
         FETCH: begin
            if (accept) nextState = DECODE;
         end
         DECODE: begin
            nextState = isLegal ? EXEC : HALT;
         end
         EXEC: begin
            case (opcode)
               OP_LW, OP_SW: nextState = MEM;
               OP_BEQ, OP_J: begin
                  nextState  = FETCH;
                  retireNext = 1'b1;
               end
               default:      nextState = WB;
            endcase
         end
         MEM: begin
            if (accept) begin
               if (opcode == OP_SW) begin
                  nextState  = FETCH;
                  retireNext = 1'b1;
               end else begin
                  nextState = WB;
               end
            end
         end
         WB: begin
            nextState  = FETCH;
            retireNext = 1'b1;
         end
         HALT: begin
            nextState = HALT;
         end
         default: begin
            nextState = FETCH;
         end
      endcase
      memReqNext = (nextState == FETCH) || (nextState == MEM);
   end

   // Control registers; reset drops any pending request at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FETCH;
         memReq    <= 1'b0;
         retireReg <= 1'b0;
      end else begin
         state     <= nextState;
         memReq    <= memReqNext;
         retireReg <= retireNext;
      end
   end

   // Datapath registers, updated according to the phase being executed.
   // PC is bumped at fetch, so branch offsets are relative to PC+4.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc     <= RESET_PC;
         instr  <= '0;
         regA   <= '0;
         regB   <= '0;
         immExt <= '0;
         aluOut <= '0;
         mdr    <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (accept) begin
                  instr <= mem_rdata;
                  pc    <= pc + 32'd4;
               end
            end
            DECODE: begin
               regA   <= rsData;
               regB   <= rtData;
               immExt <= {{16{instr[15]}}, instr[15:0]};
            end
            EXEC: begin
               aluOut <= aluResult;
               if (opcode == OP_BEQ && regA == regB) begin
                  pc <= pc + {immExt[29:0], 2'b00};
               end else if (opcode == OP_J) begin
                  pc <= {pc[31:28], instr[25:0], 2'b00};
               end
            end
            MEM: begin
               if (accept && opcode == OP_LW) mdr <= mem_rdata;
            end
            default: begin
            end
         endcase
      end
   end

   // Architectural register file, written only in WB so the update lands on
   // the same edge as retire.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regFile[i] <= '0;
      end else if (state == WB && wbEnable) begin
         regFile[wbIdx] <= wbData;
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for the multi-cycle core: a wait-state memory model serves
// the default-sized core, a zero-wait model serves an 8-register instance.
module tb_multicycle_datapath;

   logic        clk;
   logic        reset;
   logic        memReq, memWe, memReady, retire, halted;
   logic [31:0] memAddr, memWdata, memRdata, pcOut;
   logic        memReq8, memWe8, memReady8, retire8, halted8;
   logic [31:0] memAddr8, memWdata8, memRdata8, pcOut8;

   logic [31:0] mem  [256];
   logic [31:0] mem8 [64];
   int          waitCycles;
   int          waitCount;
   int          testCount;
   int          failCount;

   multicycle_datapath dut (
      .clk(clk), .reset(reset),
      .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .mem_ready(memReady),
      .pc_out(pcOut), .retire(retire), .halted(halted)
   );

   multicycle_datapath #(.NUM_REGS(8)) dut8 (
      .clk(clk), .reset(reset),
      .mem_req(memReq8), .mem_we(memWe8), .mem_addr(memAddr8), .mem_wdata(memWdata8),
      .mem_rdata(memRdata8), .mem_ready(memReady8),
      .pc_out(pcOut8), .retire(retire8), .halted(halted8)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'h00, funct};
   endfunction

   function automatic logic [31:0] encJ(input logic [25:0] target);
      return {6'h02, target};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One clock: memories answer at the falling edge, stores commit at the
   // rising edge unless reset is high, outputs are then sampled 1 unit later.
   task automatic applyStimulus();
      logic        acc, req, we, acc8, we8;
      logic [31:0] addr, wdata, addr8, wdata8;
      @(negedge clk);
      if (memReq && waitCount >= waitCycles) begin
         memReady = 1'b1;
         memRdata = mem[memAddr[9:2]];
      end else begin
         memReady = 1'b0;
         memRdata = '0;
      end
      req   = memReq;
      acc   = memReq && memReady;
      we    = memWe;
      addr  = memAddr;
      wdata = memWdata;
      memReady8 = memReq8;
      memRdata8 = memReq8 ? mem8[memAddr8[7:2]] : '0;
      acc8   = memReq8;
      we8    = memWe8;
      addr8  = memAddr8;
      wdata8 = memWdata8;
      @(posedge clk);
      if (reset) begin
         waitCount = 0;
      end else if (acc) begin
         if (we) mem[addr[9:2]] = wdata;
         waitCount = 0;
      end else if (req) begin
         waitCount++;
      end
      if (!reset && acc8 && we8) mem8[addr8[7:2]] = wdata8;
      #1;
   endtask

   task automatic waitRetire(input string tag, input int expLat);
      int n;
      n = 0;
      do begin
         applyStimulus();
         n++;
      end while (!retire && n < 40);
      checkOutput(tag, 32'(n), 32'(expLat));
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
   endtask

   task automatic loadWord(input logic [31:0] addr, input logic [31:0] data);
      mem[addr[9:2]] = data;
   endtask

   task automatic loadWord8(input logic [31:0] addr, input logic [31:0] data);
      mem8[addr[7:2]] = data;
   endtask

   task automatic prefill8();
      for (int i = 16; i < 20; i++) mem8[i] = 32'hAAAA_AAAA;
   endtask

   initial begin
      logic anyReq;
      reset      = 1'b1;
      memReady   = 1'b0;
      memRdata   = '0;
      memReady8  = 1'b0;
      memRdata8  = '0;
      waitCycles = 0;
      waitCount  = 0;
      testCount  = 0;
      failCount  = 0;

      for (int i = 0; i < 256; i++) mem[i] = '0;
      for (int i = 0; i < 64; i++) mem8[i] = '0;

      // Program A: arithmetic, stores, branches, jump, illegal opcode.
      loadWord(32'h00, encI(6'h08, 5'd0, 5'd1, 16'd5));
      loadWord(32'h04, encI(6'h08, 5'd0, 5'd2, 16'd7));
      loadWord(32'h08, encR(5'd1, 5'd2, 5'd3, 6'h20));
      loadWord(32'h0C, encR(5'd1, 5'd2, 5'd4, 6'h22));
      loadWord(32'h10, encR(5'd4, 5'd1, 5'd6, 6'h2A));
      loadWord(32'h14, encI(6'h08, 5'd0, 5'd0, 16'd9));
      loadWord(32'h18, encI(6'h2B, 5'd0, 5'd3, 16'h0080));
      loadWord(32'h1C, encI(6'h2B, 5'd0, 5'd4, 16'h0084));
      loadWord(32'h20, encI(6'h2B, 5'd0, 5'd6, 16'h0088));
      loadWord(32'h24, encI(6'h2B, 5'd0, 5'd0, 16'h008C));
      loadWord(32'h28, encI(6'h04, 5'd1, 5'd2, 16'd1));
      loadWord(32'h2C, encJ(26'h40));
      loadWord(32'h100, encI(6'h04, 5'd1, 5'd1, 16'hFFFE));
      loadWord(32'hFC, 32'hFC00_0000);
      loadWord(32'h8C, 32'hDEAD_BEEF);

      // Program for the 8-register core: out-of-range register, and/or,
      // then an unsupported R-type funct.
      loadWord8(32'h00, encI(6'h08, 5'd0, 5'd9, 16'd3));
      loadWord8(32'h04, encR(5'd9, 5'd0, 5'd1, 6'h20));
      loadWord8(32'h08, encI(6'h08, 5'd0, 5'd2, 16'd6));
      loadWord8(32'h0C, encI(6'h08, 5'd0, 5'd3, 16'd12));
      loadWord8(32'h10, encR(5'd2, 5'd3, 5'd4, 6'h24));
      loadWord8(32'h14, encR(5'd2, 5'd3, 5'd5, 6'h25));
      loadWord8(32'h18, encI(6'h2B, 5'd0, 5'd1, 16'h0040));
      loadWord8(32'h1C, encI(6'h2B, 5'd0, 5'd4, 16'h0044));
      loadWord8(32'h20, encI(6'h2B, 5'd0, 5'd5, 16'h0048));
      loadWord8(32'h24, encI(6'h2B, 5'd0, 5'd9, 16'h004C));
      loadWord8(32'h28, encR(5'd0, 5'd0, 5'd0, 6'h21));
      prefill8();

      applyStimulus();
      applyStimulus();
      checkOutput("rst_mem_req", 32'(memReq), 32'd0);
      checkOutput("rst_mem_we", 32'(memWe), 32'd0);
      checkOutput("rst_retire", 32'(retire), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_pc", pcOut, 32'h0);
      reset = 1'b0;

      applyStimulus();
      checkOutput("first_fetch_req", 32'(memReq), 32'd1);
      checkOutput("first_fetch_addr", memAddr, 32'h0);

      for (int k = 1; k <= 4; k++) begin
         applyStimulus();
         applyStimulus();
         applyStimulus();
         checkOutput("retire_early", 32'(retire), 32'd0);
         applyStimulus();
         checkOutput("retire_at_4k", 32'(retire), 32'd1);
         checkOutput("next_fetch_addr", memAddr, 32'(4 * k));
      end

      waitRetire("slt_lat", 4);
      waitRetire("addi_r0_lat", 4);
      waitRetire("sw_r3_lat", 4);
      waitRetire("sw_r4_lat", 4);
      waitRetire("sw_r6_lat", 4);
      waitRetire("sw_r0_lat", 4);
      waitRetire("beq_nt_lat", 3);
      checkOutput("beq_nt_target", memAddr, 32'h2C);
      waitRetire("j_lat", 3);
      checkOutput("j_target", memAddr, 32'h100);
      waitRetire("beq_t_lat", 3);
      checkOutput("beq_t_target", memAddr, 32'hFC);

      applyStimulus();
      checkOutput("not_halted_in_decode", 32'(halted), 32'd0);
      applyStimulus();
      checkOutput("halted", 32'(halted), 32'd1);
      checkOutput("halt_pc", pcOut, 32'h100);
      anyReq = memReq;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         anyReq = anyReq | memReq | retire;
      end
      checkOutput("halt_quiet", 32'(anyReq), 32'd0);
      checkOutput("halt_sticky", 32'(halted), 32'd1);

      checkOutput("mem_add_r3", mem[32], 32'd12);
      checkOutput("mem_sub_r4", mem[33], 32'hFFFF_FFFE);
      checkOutput("mem_slt_r6", mem[34], 32'd1);
      checkOutput("mem_r0_zero", mem[35], 32'd0);

      // Program B: store/load through a memory with two wait states.
      for (int i = 0; i < 256; i++) mem[i] = '0;
      loadWord(32'h00, encI(6'h08, 5'd0, 5'd3, 16'd12));
      loadWord(32'h04, encI(6'h2B, 5'd0, 5'd3, 16'h0048));
      loadWord(32'h08, encI(6'h23, 5'd0, 5'd5, 16'h0048));
      loadWord(32'h0C, encI(6'h2B, 5'd0, 5'd5, 16'h004C));
      loadWord(32'h10, encI(6'h23, 5'd0, 5'd7, 16'h0050));
      loadWord(32'h50, 32'h0000_0055);
      waitCycles = 2;
      doReset();
      checkOutput("halt_exit_by_reset", 32'(halted), 32'd0);
      applyStimulus();
      waitRetire("addi_wait_lat", 6);

      for (int e = 1; e <= 4; e++) applyStimulus();
      for (int e = 5; e <= 7; e++) begin
         applyStimulus();
         checkOutput("sw_wait_req", 32'(memReq), 32'd1);
         checkOutput("sw_wait_we", 32'(memWe), 32'd1);
         checkOutput("sw_wait_addr", memAddr, 32'h48);
         checkOutput("sw_wait_wdata", memWdata, 32'd12);
      end
      checkOutput("sw_no_early_retire", 32'(retire), 32'd0);
      applyStimulus();
      checkOutput("sw_retire_at_8", 32'(retire), 32'd1);
      checkOutput("sw_mem_written", mem[18], 32'd12);

      waitRetire("lw_wait_lat", 9);
      waitRetire("sw_r5_wait_lat", 8);
      checkOutput("lw_r5_value", mem[19], 32'd12);

      // Reset while the lw r7 access is stalled in MEM.
      waitCycles = 0;
      applyStimulus();
      applyStimulus();
      waitCycles = 100;
      applyStimulus();
      checkOutput("lw_mem_req", 32'(memReq), 32'd1);
      checkOutput("lw_mem_we", 32'(memWe), 32'd0);
      checkOutput("lw_mem_addr", memAddr, 32'h50);
      applyStimulus();
      applyStimulus();
      checkOutput("lw_req_held", 32'(memReq), 32'd1);
      reset      = 1'b1;
      waitCycles = 2;
      prefill8();
      applyStimulus();
      checkOutput("midrst_pc", pcOut, 32'h0);
      checkOutput("midrst_req", 32'(memReq), 32'd0);
      checkOutput("midrst_retire", 32'(retire), 32'd0);
      reset      = 1'b0;
      waitCycles = 0;
      applyStimulus();
      checkOutput("restart_req", 32'(memReq), 32'd1);
      checkOutput("restart_addr", memAddr, 32'h0);

      for (int i = 0; i < 50; i++) applyStimulus();
      checkOutput("progB_halted", 32'(halted), 32'd1);
      checkOutput("progB_halt_pc", pcOut, 32'h18);
      checkOutput("r8_halted", 32'(halted8), 32'd1);
      checkOutput("r8_halt_pc", pcOut8, 32'h2C);
      checkOutput("r8_add_r9", mem8[16], 32'd0);
      checkOutput("r8_and", mem8[17], 32'd4);
      checkOutput("r8_or", mem8[18], 32'd14);
      checkOutput("r8_read_r9", mem8[19], 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
